// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared opcodes, state encodings and mux/ALU-op codes for the MCPU
package mcpu_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_SLT   = 3'b100;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Unknown opcodes map to S_FETCH, which the FSM treats as the illegal-instruction case.
  function automatic state_t decode_next(input logic [5:0] op);
    case (op)
      OP_LW, OP_SW:               return S_MEMADR;
      OP_R:                       return S_EXEC;
      OP_BEQ, OP_BNE:             return S_BRANCH;
      OP_ADDI, OP_ANDI, OP_SLTI:  return S_IMMEX;
      OP_J:                       return S_JUMP;
      default:                    return S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/mcpu_main_control.sv
// rtl/mcpu_main_control.sv - multicycle main control FSM and retired-instruction counter
module mcpu_main_control
  import mcpu_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [5:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_PCWrite,
  output logic             o_IorD,
  output logic             o_MemRead,
  output logic             o_MemWrite,
  output logic             o_IRWrite,
  output logic             o_RegDst,
  output logic             o_MemtoReg,
  output logic             o_RegWrite,
  output logic             o_ALUSrcA,
  output logic [1:0]       o_ALUSrcB,
  output logic [2:0]       o_ALUop,
  output logic [1:0]       o_PCSource,
  output logic [3:0]       o_state,
  output logic             o_instr_done,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_RST;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d      = S_FETCH;
    o_PCWrite    = 1'b0;
    o_IorD       = 1'b0;
    o_MemRead    = 1'b0;
    o_MemWrite   = 1'b0;
    o_IRWrite    = 1'b0;
    o_RegDst     = 1'b0;
    o_MemtoReg   = 1'b0;
    o_RegWrite   = 1'b0;
    o_ALUSrcA    = 1'b0;
    o_ALUSrcB    = SRCB_B;
    o_ALUop      = ALUOP_ADD;
    o_PCSource   = PCSRC_ALU;
    o_instr_done = 1'b0;
    o_illegal    = 1'b0;

    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        o_MemRead = 1'b1;
        o_ALUSrcB = SRCB_FOUR;
        o_IRWrite = i_mem_ready;
        o_PCWrite = i_mem_ready;
        state_d   = i_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        o_ALUSrcB = SRCB_IMMSH;
        state_d   = decode_next(i_opcode);
        o_illegal = (state_d == S_FETCH);
      end
      S_MEMADR: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = SRCB_IMM;
        state_d   = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        o_IorD    = 1'b1;
        o_MemRead = 1'b1;
        state_d   = i_mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        o_MemtoReg   = 1'b1;
        o_RegWrite   = 1'b1;
        o_instr_done = 1'b1;
      end
      S_MEMWR: begin
        o_IorD       = 1'b1;
        o_MemWrite   = 1'b1;
        o_instr_done = i_mem_ready;
        state_d      = i_mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXEC: begin
        o_ALUSrcA = 1'b1;
        o_ALUop   = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        o_RegDst     = 1'b1;
        o_RegWrite   = 1'b1;
        o_instr_done = 1'b1;
      end
      S_BRANCH: begin
        // ALU subtract sets i_zero; the PC write is qualified here so the datapath needs no gate.
        o_ALUSrcA    = 1'b1;
        o_ALUop      = ALUOP_SUB;
        o_PCSource   = PCSRC_ALUOUT;
        o_PCWrite    = (i_opcode == OP_BEQ) ? i_zero : !i_zero;
        o_instr_done = 1'b1;
      end
      S_IMMEX: begin
        o_ALUSrcA = 1'b1;
        o_ALUSrcB = SRCB_IMM;
        case (i_opcode)
          OP_ANDI: o_ALUop = ALUOP_AND;
          OP_SLTI: o_ALUop = ALUOP_SLT;
          default: o_ALUop = ALUOP_ADD;
        endcase
        state_d = S_IMMWB;
      end
      S_IMMWB: begin
        o_RegWrite   = 1'b1;
        o_instr_done = 1'b1;
      end
      S_JUMP: begin
        o_PCSource   = PCSRC_JUMP;
        o_PCWrite    = 1'b1;
        o_instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign retired_d = retired_q + CNT_W'(o_instr_done);
  assign o_retired = retired_q;
  assign o_state   = state_q;

endmodule

// File: tb/tb_mcpu_main_control.sv
// tb/tb_mcpu_main_control.sv - directed-vector bench for the MCPU main control FSM
module tb_mcpu_main_control;
  import mcpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       ready;
  logic       pcw, iord, mr, mw, irw, rdst, m2r, rw, srca;
  logic [1:0] srcb, pcs;
  logic [2:0] aluop;
  logic [3:0] st;
  logic       done, ill;
  logic [3:0] retired;

  int n_vec = 0;
  int n_err = 0;
  int exp_ret = 0;

  logic [21:0] obs;
  assign obs = {st, pcw, iord, mr, mw, irw, rdst, m2r, rw, srca, srcb, aluop, pcs, done, ill};

  mcpu_main_control #(.CNT_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(ready),
    .o_PCWrite(pcw), .o_IorD(iord), .o_MemRead(mr), .o_MemWrite(mw), .o_IRWrite(irw),
    .o_RegDst(rdst), .o_MemtoReg(m2r), .o_RegWrite(rw), .o_ALUSrcA(srca),
    .o_ALUSrcB(srcb), .o_ALUop(aluop), .o_PCSource(pcs), .o_state(st),
    .o_instr_done(done), .o_illegal(ill), .o_retired(retired)
  );

  always #5 clk = ~clk;

  // Fields: {state, PCWrite,IorD,MemRead,MemWrite,IRWrite, RegDst,MemtoReg,RegWrite,ALUSrcA,
  //          ALUSrcB, ALUop, PCSource, instr_done, illegal}
  function automatic logic [21:0] exp_of(input int s, input logic f, input logic [2:0] op);
    case (s)
      1:  return {4'd1,  f, 1'b0, 1'b1, 1'b0, f, 4'b0000, 2'b01, 3'b000, 2'b00, 2'b00};
      2:  return {4'd2,  5'b00000, 4'b0000, 2'b11, 3'b000, 2'b00, 1'b0, f};
      3:  return {4'd3,  5'b00000, 4'b0001, 2'b10, 3'b000, 2'b00, 2'b00};
      4:  return {4'd4,  5'b01100, 4'b0000, 2'b00, 3'b000, 2'b00, 2'b00};
      5:  return {4'd5,  5'b00000, 4'b0110, 2'b00, 3'b000, 2'b00, 2'b10};
      6:  return {4'd6,  5'b01010, 4'b0000, 2'b00, 3'b000, 2'b00, f, 1'b0};
      7:  return {4'd7,  5'b00000, 4'b0001, 2'b00, 3'b010, 2'b00, 2'b00};
      8:  return {4'd8,  5'b00000, 4'b1010, 2'b00, 3'b000, 2'b00, 2'b10};
      9:  return {4'd9,  f, 4'b0000, 4'b0001, 2'b00, 3'b001, 2'b01, 2'b10};
      10: return {4'd10, 5'b00000, 4'b0001, 2'b10, op, 2'b00, 2'b00};
      11: return {4'd11, 5'b00000, 4'b0010, 2'b00, 3'b000, 2'b00, 2'b10};
      12: return {4'd12, 5'b10000, 4'b0000, 2'b00, 3'b000, 2'b10, 2'b10};
      default: return 22'd0;
    endcase
  endfunction

  task automatic test_reset();
    #1;
    n_vec++;
    if (obs !== 22'd0) begin
      n_err++; $display("FAIL reset_outputs got %h want %h", obs, 22'd0);
    end
    n_vec++;
    if (retired !== 4'd0) begin
      n_err++; $display("FAIL reset_retired got %0d want 0", retired);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_memwr();
    int s[4] = '{1, 2, 3, 6};
    int f[4] = '{1, 0, 0, 0};
    int r[4] = '{1, 1, 1, 0};
    opcode = OP_SW;
    for (int k = 0; k < 4; k++) begin
      ready = r[k][0];
      #1;
      n_vec++;
      if (obs !== exp_of(s[k], f[k][0], 3'b000)) begin
        n_err++; $display("FAIL rst_mid[%0d] got %h want %h", k, obs, exp_of(s[k], f[k][0], 3'b000));
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== 22'd0) begin
      n_err++; $display("FAIL rst_mid_async got %h want %h", obs, 22'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_vec++;
    if (obs !== 22'd0 || retired !== 4'(exp_ret)) begin
      n_err++; $display("FAIL rst_mid_release got %h/%0d want %h/%0d", obs, retired, 22'd0, exp_ret);
    end
    @(posedge clk); #1;
    ready = 1'b0;
    #1;
    n_vec++;
    if (obs !== exp_of(1, 1'b0, 3'b000)) begin
      n_err++; $display("FAIL rst_mid_fetch got %h want %h", obs, exp_of(1, 1'b0, 3'b000));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_rtype();
    int s[4] = '{1, 2, 7, 8};
    int f[4] = '{1, 0, 0, 0};
    opcode = OP_R;
    ready  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++;
      if (obs !== exp_of(s[k], f[k][0], 3'b000)) begin
        n_err++; $display("FAIL rtype[%0d] got %h want %h", k, obs, exp_of(s[k], f[k][0], 3'b000));
      end
      @(posedge clk); #1;
    end
    exp_ret++;
    n_vec++;
    if (retired !== 4'(exp_ret)) begin
      n_err++; $display("FAIL rtype_retired got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_lw_wait();
    int s[8] = '{1, 1, 1, 2, 3, 4, 4, 5};
    int f[8] = '{0, 0, 1, 0, 0, 0, 0, 0};
    int r[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    opcode = OP_LW;
    for (int k = 0; k < 8; k++) begin
      ready = r[k][0];
      #1;
      n_vec++;
      if (obs !== exp_of(s[k], f[k][0], 3'b000)) begin
        n_err++; $display("FAIL lw[%0d] got %h want %h", k, obs, exp_of(s[k], f[k][0], 3'b000));
      end
      @(posedge clk); #1;
    end
    exp_ret++;
    n_vec++;
    if (retired !== 4'(exp_ret) || st !== 4'd1) begin
      n_err++; $display("FAIL lw_end got %0d/st%0d want %0d/st1", retired, st, exp_ret);
    end
  endtask

  task automatic test_branch();
    int         s[9] = '{1, 2, 9, 1, 2, 9, 1, 2, 9};
    int         f[9] = '{1, 0, 1, 1, 0, 0, 1, 0, 1};
    int         z[9] = '{1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [5:0] o[9] = '{OP_BEQ, OP_BEQ, OP_BEQ, OP_BNE, OP_BNE, OP_BNE, OP_BNE, OP_BNE, OP_BNE};
    ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      opcode = o[k];
      zero   = z[k][0];
      #1;
      n_vec++;
      if (obs !== exp_of(s[k], f[k][0], 3'b000)) begin
        n_err++; $display("FAIL branch[%0d] got %h want %h", k, obs, exp_of(s[k], f[k][0], 3'b000));
      end
      @(posedge clk); #1;
    end
    exp_ret += 3;
    n_vec++;
    if (retired !== 4'(exp_ret)) begin
      n_err++; $display("FAIL branch_retired got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_illegal_andi();
    int         s[6] = '{1, 2, 1, 2, 10, 11};
    int         f[6] = '{1, 1, 1, 0, 0, 0};
    logic [2:0] a[6] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b000};
    logic [5:0] o[6] = '{6'b111111, 6'b111111, OP_ANDI, OP_ANDI, OP_ANDI, OP_ANDI};
    ready = 1'b1;
    zero  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      opcode = o[k];
      #1;
      n_vec++;
      if (obs !== exp_of(s[k], f[k][0], a[k])) begin
        n_err++; $display("FAIL illegal_andi[%0d] got %h want %h", k, obs, exp_of(s[k], f[k][0], a[k]));
      end
      @(posedge clk); #1;
    end
    exp_ret++;
    n_vec++;
    if (retired !== 4'(exp_ret)) begin
      n_err++; $display("FAIL illegal_retired got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_back_to_back();
    int         s[16] = '{1, 2, 12, 1, 2, 10, 11, 1, 2, 10, 11, 1, 2, 3, 6, 6};
    int         f[16] = '{1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
    int         r[16] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    logic [2:0] a[16] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b000, 3'd0, 3'd0,
                          3'd0, 3'b100, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [5:0] o[16] = '{OP_J, OP_J, OP_J, OP_ADDI, OP_ADDI, OP_ADDI, OP_ADDI,
                          OP_SLTI, OP_SLTI, OP_SLTI, OP_SLTI, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW};
    for (int k = 0; k < 16; k++) begin
      opcode = o[k];
      ready  = r[k][0];
      #1;
      n_vec++;
      if (obs !== exp_of(s[k], f[k][0], a[k])) begin
        n_err++; $display("FAIL b2b[%0d] got %h want %h", k, obs, exp_of(s[k], f[k][0], a[k]));
      end
      @(posedge clk); #1;
    end
    exp_ret += 4;
    n_vec++;
    if (retired !== 4'(exp_ret)) begin
      n_err++; $display("FAIL b2b_retired got %0d want %0d", retired, exp_ret);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    #1;
    exp_ret = 0;
    n_vec++;
    if (retired !== 4'd0) begin
      n_err++; $display("FAIL wrap_reset got %0d want 0", retired);
    end
    @(posedge clk); #1;
    rst    = 1'b0;
    opcode = OP_J;
    ready  = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 17 * 3; k++) begin
      @(posedge clk); #1;
    end
    exp_ret = 17;
    n_vec++;
    if (retired !== 4'(exp_ret) || st !== 4'd1) begin
      n_err++; $display("FAIL wrap_retired got %0d/st%0d want %0d/st1", retired, st, exp_ret % 16);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    opcode = OP_R;
    zero   = 1'b0;
    ready  = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_reset_mid_memwr();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_illegal_andi();
    test_back_to_back();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
